button_led_host_link: RTL and testbench

- Host-side end of the button/LED virtual-interface UART link.
- Serializes a 24-bit button snapshot into 4-byte frames toward the FPGA device.
- Deserializes single-byte LED state frames coming back and presents them as `leds` with a valid strobe.
- Used as a hardware host emulator for loopback benches and board-to-board bring-up.

---
 rtl/button_led_host_link_if.sv | 21 ++
 rtl/button_led_host_link.sv | 190 +++++++++++++++++++
 tb/tb_button_led_host_link.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_led_host_link_if.sv
// Host-link signal bundle: UART lines, button snapshot in, LED state out.
// The design end uses the slave modport; the host/bench end uses master.
interface button_led_host_link_if;
    logic        rx;
    logic        tx;
    logic [23:0] buttons;
    logic [7:0]  leds;
    logic        leds_valid;
    logic        frame_err;
    logic        tx_busy;

    modport master (
        output rx, buttons,
        input  tx, leds, leds_valid, frame_err, tx_busy
    );

    modport slave (
        input  rx, buttons,
        output tx, leds, leds_valid, frame_err, tx_busy
    );
endinterface

// File: rtl/button_led_host_link.sv
// Host end of the button/LED UART link: 4-byte button frames out,
// single-byte LED frames in (8N1, LSB first).
module button_led_host_link #(
    parameter logic        SEND_ON_CHANGE = 1'b0,
    parameter int          CLKS_PER_BIT   = 870,
    parameter logic [31:0] CLKS_PER_SYNC  = 32'd1666666,
    parameter logic [7:0]  FRAME_HEADER   = 8'hA5
) (
    input logic                   CLK,
    input logic                   RST,
    button_led_host_link_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [1:0]    r_tx_byte;
    logic [7:0]    r_tx_shift;
    logic          r_tx;
    logic          r_tx_busy;
    logic          r_pending;
    logic [23:0]   r_snap;
    logic [31:0]   r_sync_cnt;
    logic          w_sync_trig;
    logic          w_chg_trig;
    logic [7:0]    w_next_byte;

    state_t        r_rx_state;
    logic          r_rx_s1;
    logic          r_rx_s2;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_leds;
    logic          r_leds_valid;
    logic          r_frame_err;

    assign w_sync_trig = (CLKS_PER_SYNC != 32'd0) &&
                         (r_sync_cnt == CLKS_PER_SYNC - 32'd1);
    assign w_chg_trig  = SEND_ON_CHANGE && (bus.buttons != r_snap);

    always_comb begin
        w_next_byte = r_snap[23:16];
        unique case (1'b1)
            (r_tx_byte == 2'd0): w_next_byte = r_snap[7:0];
            (r_tx_byte == 2'd1): w_next_byte = r_snap[15:8];
            default:             w_next_byte = r_snap[23:16];
        endcase
    end

    // Free-running periodic timer, independent of frame activity
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync_cnt <= 32'd0;
        end else if (CLKS_PER_SYNC == 32'd0 || w_sync_trig) begin
            r_sync_cnt <= 32'd0;
        end else begin
            r_sync_cnt <= r_sync_cnt + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_byte  <= 2'd0;
            r_tx_shift <= 8'h00;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_pending  <= 1'b0;
            r_snap     <= 24'h0;
        end else begin
            if (w_sync_trig || w_chg_trig) r_pending <= 1'b1;
            unique case (r_tx_state)
                S_IDLE: if (r_pending) begin
                    // Change trigger this cycle is satisfied by this capture
                    r_snap     <= bus.buttons;
                    r_pending  <= w_sync_trig;
                    r_tx_busy  <= 1'b1;
                    r_tx       <= 1'b0;
                    r_tx_shift <= FRAME_HEADER;
                    r_tx_cnt   <= '0;
                    r_tx_byte  <= 2'd0;
                    r_tx_state <= S_START;
                end
                S_START: if (r_tx_cnt == BIT_LAST) begin
                    r_tx_cnt   <= '0;
                    r_tx_bit   <= 3'd0;
                    r_tx       <= r_tx_shift[0];
                    r_tx_state <= S_DATA;
                end else begin
                    r_tx_cnt <= r_tx_cnt + CW'(1);
                end
                S_DATA: if (r_tx_cnt == BIT_LAST) begin
                    r_tx_cnt <= '0;
                    if (r_tx_bit == 3'd7) begin
                        r_tx       <= 1'b1;
                        r_tx_state <= S_STOP;
                    end else begin
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx       <= r_tx_shift[1];
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + CW'(1);
                end
                S_STOP: if (r_tx_cnt == BIT_LAST) begin
                    r_tx_cnt <= '0;
                    if (r_tx_byte == 2'd3) begin
                        r_tx_busy  <= 1'b0;
                        r_tx_state <= S_IDLE;
                    end else begin
                        r_tx_byte  <= r_tx_byte + 2'd1;
                        r_tx_shift <= w_next_byte;
                        r_tx       <= 1'b0;
                        r_tx_state <= S_START;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + CW'(1);
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_state   <= S_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= 3'd0;
            r_rx_shift   <= 8'h00;
            r_leds       <= 8'h00;
            r_leds_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_s1      <= bus.rx;
            r_rx_s2      <= r_rx_s1;
            r_leds_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            unique case (r_rx_state)
                S_IDLE: if (!r_rx_s2) begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= S_START;
                end
                S_START: if (r_rx_cnt == HALF_LAST) begin
                    r_rx_cnt   <= '0;
                    r_rx_bit   <= 3'd0;
                    r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                end else begin
                    r_rx_cnt <= r_rx_cnt + CW'(1);
                end
                S_DATA: if (r_rx_cnt == BIT_LAST) begin
                    r_rx_cnt   <= '0;
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                end else begin
                    r_rx_cnt <= r_rx_cnt + CW'(1);
                end
                S_STOP: if (r_rx_cnt == BIT_LAST) begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= S_IDLE;
                    if (r_rx_s2) begin
                        r_leds       <= r_rx_shift;
                        r_leds_valid <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else begin
                    r_rx_cnt <= r_rx_cnt + CW'(1);
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx         = r_tx;
    assign bus.tx_busy    = r_tx_busy;
    assign bus.leds       = r_leds;
    assign bus.leds_valid = r_leds_valid;
    assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_button_led_host_link.sv
// Bench for button_led_host_link: frame-level model checked every cycle
// plus literal expectations on decoded frames and pulse timing.
module tb_button_led_host_link;
    localparam int CPB   = 4;
    localparam int LOGN  = 4096;
    localparam int RXLAT = 2 + CPB / 2 + 9 * CPB;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    button_led_host_link_if bus0 ();
    button_led_host_link_if bus1 ();

    button_led_host_link #(
        .SEND_ON_CHANGE(1'b1), .CLKS_PER_BIT(CPB), .CLKS_PER_SYNC(32'd0)
    ) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));

    button_led_host_link #(
        .SEND_ON_CHANGE(1'b0), .CLKS_PER_BIT(CPB), .CLKS_PER_SYNC(32'd200)
    ) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          m_k     [2];
    logic        m_act   [2];
    int          m_start [2];
    logic        m_pend  [2];
    logic [23:0] m_snap  [2];
    logic        m_rx_live = 1'b0;
    int          m_rx_t  = 0;
    logic [7:0]  m_rx_d  = 8'h00;
    logic        m_rx_stop = 1'b1;
    logic [7:0]  m_leds  = 8'h00;
    logic        m_v = 1'b0;
    logic        m_e = 1'b0;

    logic txl [2][LOGN];
    logic bl  [2][LOGN];
    logic vl  [LOGN];
    logic el  [LOGN];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [23:0] b, input int j);
        logic [7:0] by;
        int p;
        case (j / 10)
            0:       by = 8'hA5;
            1:       by = b[7:0];
            2:       by = b[15:8];
            default: by = b[23:16];
        endcase
        p = j % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p-1];
    endfunction

    // Frame-level model: triggers, pending collapse, frame occupancy, RX events
    always @(posedge CLK) begin
        int n;
        n = cyc;
        cyc = cyc + 1;
        m_v = 1'b0;
        m_e = 1'b0;
        if (RST) begin
            for (int d = 0; d < 2; d++) begin
                m_k[d] = 0; m_act[d] = 1'b0; m_start[d] = 0;
                m_pend[d] = 1'b0; m_snap[d] = 24'h0;
            end
            m_rx_live = 1'b0;
            m_leds = 8'h00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [23:0] b;
                logic st, syn, chg;
                b   = (d == 0) ? bus0.buttons : bus1.buttons;
                syn = (d == 1) && (m_k[d] % 200 == 199);
                chg = (d == 0) && (b != m_snap[d]);
                st  = !m_act[d] && m_pend[d];
                if (st) begin
                    m_act[d] = 1'b1; m_start[d] = n;
                    m_snap[d] = b; m_pend[d] = syn;
                end else begin
                    if (syn || chg) m_pend[d] = 1'b1;
                    if (m_act[d] && n == m_start[d] + 40 * CPB) m_act[d] = 1'b0;
                end
                m_k[d] = m_k[d] + 1;
            end
            if (m_rx_live && n == m_rx_t + RXLAT) begin
                m_v = m_rx_stop;
                m_e = !m_rx_stop;
                if (m_rx_stop) m_leds = m_rx_d;
                m_rx_live = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        int n;
        logic et0, et1;
        n = cyc - 1;
        if (cyc > 0 && n < LOGN) begin
            txl[0][n] = bus0.tx; txl[1][n] = bus1.tx;
            bl[0][n] = bus0.tx_busy; bl[1][n] = bus1.tx_busy;
            vl[n] = bus0.leds_valid; el[n] = bus0.frame_err;
            if (!RST) begin
                et0 = m_act[0] ? exp_bit(m_snap[0], (n - m_start[0]) / CPB) : 1'b1;
                et1 = m_act[1] ? exp_bit(m_snap[1], (n - m_start[1]) / CPB) : 1'b1;
                chk("tx0", 32'(bus0.tx), 32'(et0));
                chk("busy0", 32'(bus0.tx_busy), 32'(m_act[0]));
                chk("tx1", 32'(bus1.tx), 32'(et1));
                chk("busy1", 32'(bus1.tx_busy), 32'(m_act[1]));
                chk("leds0", 32'(bus0.leds), 32'(m_leds));
                chk("valid0", 32'(bus0.leds_valid), 32'(m_v));
                chk("ferr0", 32'(bus0.frame_err), 32'(m_e));
                chk("rx1_idle", {22'd0, bus1.leds, bus1.leds_valid, bus1.frame_err}, 32'd0);
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge CLK);
        #2;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stp,
                           input int nb, output int t);
        logic [9:0] f;
        f = {stp, d, 1'b0};
        t = cyc;
        m_rx_t = cyc; m_rx_d = d; m_rx_stop = stp; m_rx_live = 1'b1;
        for (int i = 0; i < nb; i++) begin
            bus0.rx = f[i];
            step(CPB);
        end
        bus0.rx = 1'b1;
    endtask

    function automatic int find_rise(input int d, input int from, input int span);
        for (int i = from; i < from + span && i < LOGN; i++)
            if (i > 0 && bl[d][i] && !bl[d][i-1]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] dec(input int d, input int s);
        logic [31:0] r;
        logic [7:0] by;
        r = 32'd0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++)
                by[i] = txl[d][s + (b * 10 + 1 + i) * CPB + CPB / 2];
            r = {r[23:0], by};
        end
        return r;
    endfunction

    function automatic int pulses(input int a, input int b, input logic use_err);
        int c;
        c = 0;
        for (int i = a; i < b; i++) c += use_err ? int'(el[i]) : int'(vl[i]);
        return c;
    endfunction

    initial begin
        int rel, t0, s, s2, r1, r2, len, nr, t;
        bus0.rx = 1'b1; bus0.buttons = 24'h0;
        bus1.rx = 1'b1; bus1.buttons = 24'hFFFFFF;
        step(3);
        RST = 1'b0;
        rel = cyc;
        chk("rst_tx", 32'(bus0.tx), 32'd1);
        chk("rst_busy", 32'(bus0.tx_busy), 32'd0);
        chk("rst_leds", 32'(bus0.leds), 32'd0);
        chk("rst_valid", 32'(bus0.leds_valid), 32'd0);
        chk("rst_ferr", 32'(bus0.frame_err), 32'd0);

        step(5);
        bus0.buttons = 24'h123456;
        t0 = cyc;
        step(20); bus0.buttons = 24'h000001;
        step(20); bus0.buttons = 24'h000002;
        step(440);
        s = find_rise(0, t0, 50);
        chk("f1_start", s, t0 + 1);
        if (s < 0) s = t0 + 1;
        chk("f1_bytes", dec(0, s), 32'hA5563412);
        len = 0;
        while (len < 400 && bl[0][s + len]) len++;
        chk("f1_busy_len", len, 160);
        s2 = find_rise(0, s + 1, 300);
        chk("f2_start", s2, s + 161);
        if (s2 < 0) s2 = s + 161;
        chk("f2_bytes", dec(0, s2), 32'hA5020000);
        chk("no_f3", find_rise(0, s2 + 1, 250), -1);

        step(200);
        r1 = find_rise(1, rel, 250);
        chk("sync_f1", r1, rel + 200);
        if (r1 < 0) r1 = rel + 200;
        r2 = find_rise(1, r1 + 1, 250);
        chk("sync_f2", r2, rel + 400);
        chk("sync_bytes", dec(1, r1), 32'hA5FFFFFF);
        nr = 0;
        for (int i = rel + 1; i < rel + 650; i++) if (bl[1][i] && !bl[1][i-1]) nr++;
        chk("sync_count", nr, 3);

        step(2);
        send_rx(8'h5A, 1'b1, 10, t);
        step(20);
        chk("rx5a_pulse_at", 32'(vl[t + 40]), 32'd1);
        chk("rx5a_nvalid", pulses(t, t + 55, 1'b0), 1);
        chk("rx5a_nerr", pulses(t, t + 55, 1'b1), 0);
        chk("rx5a_leds", 32'(bus0.leds), 32'h5A);

        step(10);
        send_rx(8'hC3, 1'b0, 10, t);
        step(20);
        chk("rxc3_err_at", 32'(el[t + 40]), 32'd1);
        chk("rxc3_nerr", pulses(t, t + 55, 1'b1), 1);
        chk("rxc3_nvalid", pulses(t, t + 55, 1'b0), 0);
        chk("rxc3_leds", 32'(bus0.leds), 32'h5A);

        step(10);
        t = cyc;
        bus0.rx = 1'b0;
        step(CPB / 4);
        bus0.rx = 1'b1;
        step(30);
        chk("glitch_quiet", pulses(t, t + 28, 1'b0) + pulses(t, t + 28, 1'b1), 0);

        step(5);
        bus0.buttons = 24'h00ABCD;
        step(3);
        send_rx(8'hF0, 1'b1, 4, t);
        chk("pre_rst_busy", 32'(bus0.tx_busy), 32'd1);
        RST = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(bus0.tx), 32'd1);
        chk("mid_rst_busy", 32'(bus0.tx_busy), 32'd0);
        chk("mid_rst_leds", 32'(bus0.leds), 32'd0);
        bus0.buttons = 24'h0;
        step(3);
        RST = 1'b0;
        step(5);
        send_rx(8'h81, 1'b1, 10, t);
        step(20);
        chk("rx81_pulse_at", 32'(vl[t + 40]), 32'd1);
        chk("rx81_leds", 32'(bus0.leds), 32'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
